// File: rtl/mips_pkg.sv
// Shared types and constants for the mips32 front end: fetch FSM states,
// datapath word/address widths, default instruction memory depth.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 18;
  localparam int IMEM_DEPTH = 28;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load, instruction-delivery and redirect signals between the fetch
// stage and its neighbours. master = fetch stage, slave = loader/datapath.
interface instr_fetch_if #(
  parameter int AW = mips_pkg::ADDR_W
);
  import mips_pkg::*;

  logic              load_valid;
  logic [WORD_W-1:0] load_data;
  logic              load_ready;

  logic [WORD_W-1:0] instr;
  logic [AW-1:0]     pc;
  logic              instr_valid;
  logic              instr_ready;

  logic              redirect_valid;
  logic [AW-1:0]     redirect_target;

  modport master (
    input  load_valid, load_data, instr_ready, redirect_valid, redirect_target,
    output load_ready, instr, pc, instr_valid
  );

  modport slave (
    output load_valid, load_data, instr_ready, redirect_valid, redirect_target,
    input  load_ready, instr, pc, instr_valid
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x WORD_W program store: one synchronous write port, one
// asynchronous read port. Reads past DEPTH return NOP.
module imem_array
  import mips_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int WORD_W = mips_pkg::WORD_W
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  localparam int AIW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  // write port; contents are never cleared, the fetch stage's word count
  // decides which entries are live
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = ({1'b0, raddr} < (AIW+1)'(DEPTH)) ? mem[raddr] : WORD_W'(NOP);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage ahead of the mips32 datapath. Loads a program in
// IDLE, then streams it out one instruction per handshake, following
// branch/jump redirects, and reports done when the PC runs off the end.
// Optional build macro INSTR_FETCH_ALIGN_CHECK_EN: a redirect with
// target[1:0] != 0 raises fault and ends the run; without it the low bits
// are dropped and fault stays 0.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fault,
  instr_fetch_if.master bus
);

  localparam int AIW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [CW-1:0]     count;
  logic [AW-1:0]     pc_next;
  logic [WORD_W-1:0] instr_r;
  logic [AW-1:0]     pc_r;
  logic              vld_r;

  logic              load_fire;
  logic              fetch_ok;
  logic              nonempty;
  logic [AW:0]       end_addr;
  logic [AIW-1:0]    raddr;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] word0;

  assign bus.load_ready  = (state == IDLE) && (count < CW'(DEPTH));
  assign bus.instr       = instr_r;
  assign bus.pc          = pc_r;
  assign bus.instr_valid = vld_r;
  assign busy            = (state == RUN);

  assign load_fire = bus.load_valid && bus.load_ready;

  // byte address one past the last loaded word
  assign end_addr = (AW+1)'({count, 2'b00});
  assign fetch_ok = {1'b0, pc_next} < end_addr;

  // outside RUN the read port sits on word 0 so a start can issue it at once
  assign raddr = (state == RUN) ? pc_next[AIW+1:2] : '0;

  // a word loaded in the start cycle into an empty memory is word 0 itself
  assign word0    = (load_fire && count == '0) ? bus.load_data : rdata;
  assign nonempty = (count != '0) || load_fire;

`ifndef INSTR_FETCH_ALIGN_CHECK_EN
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^bus.redirect_target[1:0];
`endif

  imem_array #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_imem (
    .clock (clock),
    .we    (load_fire),
    .waddr (count[AIW-1:0]),
    .wdata (bus.load_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // fetch FSM: load/start in IDLE, stream + redirect in RUN, restart from DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pc_next <= '0;
      instr_r <= NOP;
      pc_r    <= '0;
      vld_r   <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_fire) count <= count + CW'(1);
          if (start) begin
            fault <= 1'b0;
            if (nonempty) begin
              state   <= RUN;
              instr_r <= word0;
              pc_r    <= '0;
              vld_r   <= 1'b1;
              pc_next <= AW'(4);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.redirect_valid) begin
            // flush; a handshake in this cycle counts as consumed
            vld_r   <= 1'b0;
            pc_next <= {bus.redirect_target[AW-1:2], 2'b00};
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            if (bus.redirect_target[1:0] != 2'b00) begin
              fault <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
`endif
          end else if (!vld_r || bus.instr_ready) begin
            if (fetch_ok) begin
              instr_r <= rdata;
              pc_r    <= pc_next;
              vld_r   <= 1'b1;
              pc_next <= pc_next + AW'(4);
            end else begin
              vld_r <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (start) begin
            fault <= 1'b0;
            if (count != '0) begin
              done    <= 1'b0;
              state   <= RUN;
              instr_r <= word0;
              pc_r    <= '0;
              vld_r   <= 1'b1;
              pc_next <= AW'(4);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
